// File: rtl/imm_enc.sv
// imm_enc: range-checks an immediate and scatters it into RV64 instruction fields; expands LI into LUI+ADDIW.
module imm_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_func,
  input  logic [63:0] in_imm,
  input  logic [31:0] in_base,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);
  typedef enum logic [1:0] {IDLE, ONE, LI_HI, LI_LO} state_t;
  state_t state, state_n;
  logic [31:0] enc_inst, enc_lo, pend, ie, hi_sum;
  logic enc_err, is_li, accept, fits12, fits13, fits21, fits32;
  assign is_li  = in_func == 3'b110;
  assign fits12 = &in_imm[63:11] || ~|in_imm[63:11];
  assign fits13 = &in_imm[63:12] || ~|in_imm[63:12];
  assign fits21 = &in_imm[63:20] || ~|in_imm[63:20];
  assign fits32 = &in_imm[63:31] || ~|in_imm[63:31];
  always_comb begin
    case (in_func)
      3'b001, 3'b101: enc_err = !fits12;
      3'b011:         enc_err = !fits13 || in_imm[0];
      3'b100:         enc_err = !fits21 || in_imm[0];
      3'b010:         enc_err = !fits32 || |in_imm[11:0];
      3'b110:         enc_err = !fits32;
      default:        enc_err = 1'b0;
    endcase
  end
  // a rejected immediate is zeroed, so every format clears its fields with the same expression
  assign ie     = enc_err ? 32'h0 : in_imm[31:0];
  assign hi_sum = ie + 32'h800;
  assign enc_lo = {ie[11:0], in_rd, 3'b000, in_rd, 7'b0011011};
  always_comb begin
    case (in_func)
      3'b001:  enc_inst = {ie[11:0], in_base[19:0]};
      3'b101:  enc_inst = {ie[11:5], in_base[24:12], ie[4:0], in_base[6:0]};
      3'b011:  enc_inst = {ie[12], ie[10:5], in_base[24:12], ie[4:1], ie[11], in_base[6:0]};
      3'b010:  enc_inst = {ie[31:12], in_base[11:0]};
      3'b100:  enc_inst = {ie[20], ie[10:1], ie[11], ie[19:12], in_base[11:0]};
      3'b110:  enc_inst = {hi_sum[31:12], in_rd, 7'b0110111};
      default: enc_inst = in_base;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = accept ? (is_li ? LI_HI : ONE) :
              (state == LI_HI && out_ready) ? LI_LO :
              (out_valid && out_ready) ? IDLE : state;
  always_comb begin
    out_valid = state != IDLE;
    in_ready  = state == IDLE || ((state == ONE || state == LI_LO) && out_ready);
    accept    = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst <= '0;
      out_err  <= 1'b0;
      out_last <= 1'b0;
      pend     <= '0;
    end else if (accept) begin
      out_inst <= enc_inst;
      out_err  <= enc_err;
      out_last <= !is_li;
      pend     <= enc_lo;
    end else if (state == LI_HI && out_ready) begin
      out_inst <= pend;
      out_last <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_inst <= '0;
      out_err  <= 1'b0;
      out_last <= 1'b0;
    end
  end
endmodule
